gj_axis_rx_frame_buf: RTL
=========================

GJ_AXIS_RX_FRAME_BUF -- requirements
Module: gj_axis_rx_frame_buf

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-low, port rst (rst=0 resets, sampled on posedge clk).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 10, giving buffer capacity DEPTH = 2^DEPTH_LOG2 bytes.
REQ-003 The block SHALL have parameter DROP_CNT_W, default 16, giving the width of the drop counter.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  sync active-low reset
- flush  in  1  discard all stored and partial data
- rx_tvalid  in  1  byte strobe from UART packetiser; no backpressure
- rx_tdata  in  8  received byte
- rx_tlast  in  1  last byte of frame
- m_tvalid  out  1  AXIS output valid
- m_tready  in  1  AXIS output ready
- m_tdata  out  8  output byte
- m_tlast  out  1  output frame end
- frameCnt  out  DEPTH_LOG2+1  complete frames held, not yet fully output
- level  out  DEPTH_LOG2+1  bytes held, committed plus partial
- dropPulse  out  1  one-cycle pulse per dropped frame
- dropCnt  out  DROP_CNT_W  saturating dropped-frame count

Function
REQ-005 The block SHALL be store-and-forward: a frame becomes visible on m_* only after its rx_tlast byte is written.
REQ-006 Storage SHALL be DEPTH entries of 9 bits {last,data}; wr_ptr, commit_ptr and rd_ptr SHALL be DEPTH_LOG2+1 bits and wrap modulo 2*DEPTH.
REQ-007 Full: wr_ptr-rd_ptr==DEPTH. Empty-for-read: rd_ptr==commit_ptr.
REQ-008 An rx byte accepted when not full and not dropping SHALL be written at wr_ptr, and wr_ptr SHALL increment.
REQ-009 A written byte with rx_tlast=1 SHALL set commit_ptr to the new wr_ptr and increment frameCnt in the same cycle.
REQ-010 An rx byte arriving while full SHALL enter DROP: wr_ptr rewinds to commit_ptr, dropPulse fires once, and dropCnt increments, saturating at all-ones.
REQ-011 In DROP, all rx bytes SHALL be discarded; the byte with rx_tlast=1 SHALL return the write side to ACCEPT without being written.
REQ-012 If the byte that overflows has rx_tlast=1, the frame SHALL be dropped and the write side SHALL stay in ACCEPT.
REQ-013 Write FSM states SHALL be ACCEPT and DROP only.
REQ-014 Output SHALL follow AXIS: m_tdata/m_tlast stay stable while m_tvalid=1 and m_tready=0, and m_tvalid never deasserts without a handshake.
REQ-015 With m_tready held high, output SHALL sustain 1 byte/cycle.
REQ-016 First-byte latency SHALL be exactly 2 cycles from the rx_tlast write edge to m_tvalid=1, for a synchronous-read memory with an idle output.
REQ-017 An output handshake with m_tlast=1 SHALL decrement frameCnt.
REQ-018 A simultaneous commit and output-tlast handshake SHALL leave frameCnt unchanged.
REQ-019 A simultaneous write and read SHALL both take effect in that cycle; level SHALL equal wr_ptr-rd_ptr, where rd_ptr counts bytes handed to the output stage.
REQ-020 flush=1 SHALL, in one cycle, set wr_ptr=commit_ptr=rd_ptr, empty the output stage, deassert m_tvalid, zero frameCnt, and return the FSM to ACCEPT.
REQ-021 flush SHALL leave dropCnt unchanged.
REQ-022 An rx byte coincident with flush SHALL be discarded.
REQ-023 A frame longer than DEPTH bytes SHALL always be dropped.

Reset
REQ-024 On rst=0: all pointers 0, FSM ACCEPT, m_tvalid=0, m_tdata=0, m_tlast=0, frameCnt=0, level=0, dropPulse=0, dropCnt=0.
REQ-025 Reset mid-frame SHALL discard both partial and committed data.
REQ-026 Memory contents SHALL NOT require reset.

Structure
REQ-027 A shared package gj_axis_uart_pkg SHALL hold the write-FSM state enum (ACCEPT, DROP) and the default DEPTH_LOG2 and DROP_CNT_W constants.
REQ-028 Storage SHALL be one sub-module, gj_sdp_ram: simple dual-port, synchronous read, 1-cycle latency, width 9, depth DEPTH; it SHALL map to block RAM.
REQ-029 Pointer logic, FSM and output skid stage SHALL reside in gj_axis_rx_frame_buf.

Verification
REQ-030 Three-byte frame 0x11,0x22,0x33(last), m_tready=1 -> m_tvalid exactly 2 cycles after last write; bytes out 0x11,0x22,0x33 with m_tlast on 0x33; frameCnt 1→0.
REQ-031 DEPTH_LOG2=4: 16-byte frame, then 5-byte frame with m_tready=0 -> second frame dropped; dropPulse once; dropCnt=1; first frame intact after m_tready=1.
REQ-032 DEPTH_LOG2=4: 20-byte frame -> dropped, level returns to 0, dropCnt=1; following 2-byte frame delivered correctly.
REQ-033 m_tready toggling randomly across 100 frames, pointers wrapping repeatedly -> byte-exact output, frameCnt never negative, no lost/duplicated bytes.
REQ-034 Assert flush mid-frame with one committed frame pending -> m_tvalid=0 next cycle, frameCnt=0, level=0; a new frame afterwards delivered correctly.
REQ-035 Drive rst=0 during output of a frame -> all outputs at reset values next cycle; dropCnt=0.

Source files
------------

// File: rtl/gj_axis_uart_pkg.sv
// Shared types and defaults for the UART receive-side AXIS blocks.
package gj_axis_uart_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 10;
  localparam int unsigned DROP_CNT_W_DEF = 16;

  // Write-side state: storing the current frame, or discarding it to its end.
  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_e;

  // One stored byte together with its end-of-frame marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_word_t;

  localparam int unsigned WORD_W = $bits(rx_word_t);

endpackage

// File: rtl/gj_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port (1-cycle latency).
module gj_sdp_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned W  = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Registered read and plain write, no reset, so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gj_axis_rx_frame_buf.sv
// Store-and-forward frame buffer between a UART packetiser and an AXIS sink.
// Frames become readable only once complete; frames that overflow are dropped.
module gj_axis_rx_frame_buf
  import gj_axis_uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned DROP_CNT_W = DROP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  rx_tvalid,
  input  logic [7:0]            rx_tdata,
  input  logic                  rx_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [7:0]            m_tdata,
  output logic                  m_tlast,
  output logic [DEPTH_LOG2:0]   frameCnt,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  dropPulse,
  output logic [DROP_CNT_W-1:0] dropCnt
);

  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  wr_state_e             state_q;
  logic [PW-1:0]         wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
  logic [PW-1:0]         level_q, frame_cnt_q, frame_cnt_d;
  logic                  drop_pulse_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic                  hv_q, hv_d, sv_q, sv_d, rv_q;
  rx_word_t              head_q, head_d, skid_q, skid_d, ram_rdata, wr_word;
  logic                  rx_ok, full_c, wr_en, commit_c, drop_c, rd_en, pop;
  logic [2:0]            staged;

  assign rx_ok   = rx_tvalid & ~flush;
  assign full_c  = (wr_q - rd_q) == PW'(DEPTH);
  assign wr_word = '{last: rx_tlast, data: rx_tdata};

  // Write-side pointer updates: store, commit on tlast, rewind on overflow, realign on flush.
  always_comb begin
    wr_en    = 1'b0;
    commit_c = 1'b0;
    drop_c   = 1'b0;
    wr_d     = wr_q;
    commit_d = commit_q;
    if (flush) begin
      wr_d     = rd_q;
      commit_d = rd_q;
    end else if (rx_ok && state_q == ST_ACCEPT) begin
      if (full_c) begin
        drop_c = 1'b1;
        wr_d   = commit_q;
      end else begin
        wr_en = 1'b1;
        wr_d  = wr_q + PW'(1);
        if (rx_tlast) begin
          commit_c = 1'b1;
          commit_d = wr_q + PW'(1);
        end
      end
    end
  end

  // Write FSM: an overflow without tlast discards the rest of the frame up to its tlast byte.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_q <= ST_ACCEPT;
    end else begin
      case (state_q)
        ST_ACCEPT: if (drop_c && !rx_tlast) state_q <= ST_DROP;
        ST_DROP:   if (rx_ok && rx_tlast) state_q <= ST_ACCEPT;
        default:   state_q <= ST_ACCEPT;
      endcase
    end
  end

  // Read issue: prefetch committed bytes while the two-entry output stage has room on arrival.
  assign pop    = hv_q & m_tready;
  assign staged = 3'(hv_q) + 3'(sv_q) + 3'(rv_q) - 3'(pop);
  assign rd_en  = (rd_q != commit_q) && !flush && (staged < 3'd2);
  assign rd_d   = rd_q + PW'(rd_en);

  // Output skid stage: head drives the AXIS port, skid absorbs the RAM word during a stall.
  always_comb begin
    hv_d   = hv_q;
    sv_d   = sv_q;
    head_d = head_q;
    skid_d = skid_q;
    if (pop) begin
      if (sv_q) begin
        head_d = skid_q;
        if (rv_q) skid_d = ram_rdata;
        else      sv_d   = 1'b0;
      end else if (rv_q) begin
        head_d = ram_rdata;
      end else begin
        hv_d = 1'b0;
      end
    end else if (rv_q) begin
      if (!hv_q) begin
        head_d = ram_rdata;
        hv_d   = 1'b1;
      end else begin
        skid_d = ram_rdata;
        sv_d   = 1'b1;
      end
    end
    if (flush) begin
      hv_d = 1'b0;
      sv_d = 1'b0;
    end
  end

  // Complete frames held: up on commit, down on the tlast handshake, cleared by flush.
  always_comb begin
    frame_cnt_d = frame_cnt_q + PW'(commit_c) - PW'(pop & head_q.last);
    if (flush) frame_cnt_d = '0;
  end

  // State registers for pointers, output stage and drop statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q         <= '0;
      commit_q     <= '0;
      rd_q         <= '0;
      level_q      <= '0;
      rv_q         <= 1'b0;
      hv_q         <= 1'b0;
      sv_q         <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
      frame_cnt_q  <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      wr_q         <= wr_d;
      commit_q     <= commit_d;
      rd_q         <= rd_d;
      level_q      <= wr_d - rd_d;
      rv_q         <= rd_en;
      hv_q         <= hv_d;
      sv_q         <= sv_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_pulse_q <= drop_c;
      if (drop_c && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  gj_sdp_ram #(
    .AW (DEPTH_LOG2),
    .W  (WORD_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wr_word),
    .re_i    (rd_en),
    .raddr_i (rd_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  assign m_tvalid  = hv_q;
  assign m_tdata   = head_q.data;
  assign m_tlast   = head_q.last;
  assign frameCnt  = frame_cnt_q;
  assign level     = level_q;
  assign dropPulse = drop_pulse_q;
  assign dropCnt   = drop_cnt_q;

endmodule
